// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode prefixes, ALU encodings, FSM states and control word shared by the controller.
package ctrl_pkg;
    localparam logic [1:0] OP2_ALU_R = 2'b00;
    localparam logic [1:0] OP2_ALU_I = 2'b01;
    localparam logic [2:0] OP3_SHIFT = 3'b110;
    localparam logic [2:0] OP3_MEM   = 3'b100;
    localparam logic [2:0] OP3_BR    = 3'b101;
    localparam logic [4:0] OP5_JMP   = 5'b11100;
    localparam logic [4:0] OP5_CALL  = 5'b11101;
    localparam logic [5:0] OP6_RET   = 6'b111100;
    localparam logic [1:0] MEM_LOAD  = 2'b00;
    localparam logic [1:0] MEM_STORE = 2'b01;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_MOV, ALU_MASK,
        ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR
    } alu_op_e;

    typedef enum logic {RUN, HALTED} state_e;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       const_en;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_two_addr;
        logic       branch;
        logic       jump_sel;
        logic       change;
        logic       ret_sel;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: LIFO of return addresses; pushes when full and pops when empty are ignored.
module return_addr_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(DEPTH);

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == CNT_W'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign top     = mem_q[AW'(cnt_q - CNT_W'(1))];

    always_comb begin
        cnt_d = do_push ? cnt_q + CNT_W'(1) : do_pop ? cnt_q - CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[cnt_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/pipelined_controller.sv
// pipelined_controller: registered instruction decoder with return-address stack,
// stall/flush sequencing and sticky halt/stack-error state.
module pipelined_controller
    import ctrl_pkg::*;
#(
    parameter int INSTR_W     = 19,
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc_next,
    input  logic               stall,
    input  logic               flush,
    output logic               ctrl_valid,
    output logic               reg_write,
    output logic               const_en,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               reg_two_addr,
    output logic               branch,
    output logic               jump_sel,
    output logic               change,
    output logic               ret_sel,
    output logic [3:0]         alu_op,
    output logic [PC_W-1:0]    ret_addr,
    output logic               halted,
    output logic               stk_overflow,
    output logic               stk_underflow
);
    localparam int M = INSTR_W - 1;

    state_e          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_d, dec;
    logic [PC_W-1:0] ret_addr_q, ret_addr_d, stk_top;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic            is_halt, is_call, is_ret, push, pop, stk_full, stk_empty;
    logic [1:0]      op2;
    logic [2:0]      op3, fn;
    logic [4:0]      op5;
    logic [5:0]      op6;

    assign op2 = instr[M -: 2];
    assign op3 = instr[M -: 3];
    assign op5 = instr[M -: 5];
    assign op6 = instr[M -: 6];
    assign fn  = instr[M-2 -: 3];
    assign is_halt = &instr;

    always_comb begin
        dec       = CTRL_BUBBLE;
        dec.valid = 1'b1;
        is_call   = 1'b0;
        is_ret    = 1'b0;
        if (is_halt) begin
        end else if (op2 == OP2_ALU_R || op2 == OP2_ALU_I) begin
            dec.change    = 1'b1;
            dec.reg_write = 1'b1;
            dec.const_en  = op2 == OP2_ALU_I;
            dec.alu_op    = {1'b0, fn};
        end else if (op3 == OP3_SHIFT) begin
            dec.reg_write = 1'b1;
            dec.alu_op    = ALU_SHL | {2'b00, fn[1:0]};
        end else if (op3 == OP3_MEM) begin
            dec.mem_to_reg   = 1'b1;
            dec.const_en     = 1'b1;
            dec.reg_two_addr = 1'b1;
            dec.mem_read     = fn[1:0] == MEM_LOAD;
            dec.reg_write    = fn[1:0] == MEM_LOAD;
            dec.mem_write    = fn[1:0] == MEM_STORE;
        end else if (op3 == OP3_BR) begin
            dec.branch = 1'b1;
        end else if (op5 == OP5_JMP || op5 == OP5_CALL) begin
            dec.jump_sel = 1'b1;
            is_call      = op5 == OP5_CALL;
        end else if (op6 == OP6_RET) begin
            dec.ret_sel = 1'b1;
            is_ret      = 1'b1;
        end
    end

    // Stall holds everything unless halted or flushed, even with no valid instruction.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        ret_addr_d = ret_addr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (state_q == HALTED || flush || (!stall && !instr_valid)) begin
            ctrl_d     = CTRL_BUBBLE;
            ret_addr_d = '0;
        end else if (!stall) begin
            ctrl_d     = dec;
            ret_addr_d = '0;
            if (is_halt) begin
                state_d = HALTED;
                ctrl_d  = CTRL_BUBBLE;
            end else if (is_call) begin
                if (stk_full) begin
                    ovf_d   = 1'b1;
                    state_d = HALTED;
                    ctrl_d  = CTRL_BUBBLE;
                end else begin
                    push = 1'b1;
                end
            end else if (is_ret) begin
                if (stk_empty) begin
                    unf_d   = 1'b1;
                    state_d = HALTED;
                    ctrl_d  = CTRL_BUBBLE;
                end else begin
                    pop        = 1'b1;
                    ret_addr_d = stk_top;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ctrl_q     <= CTRL_BUBBLE;
            ret_addr_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            ret_addr_q <= ret_addr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    return_addr_stack #(.PC_W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_next),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    assign ctrl_valid    = ctrl_q.valid;
    assign reg_write     = ctrl_q.reg_write;
    assign const_en      = ctrl_q.const_en;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_two_addr  = ctrl_q.reg_two_addr;
    assign branch        = ctrl_q.branch;
    assign jump_sel      = ctrl_q.jump_sel;
    assign change        = ctrl_q.change;
    assign ret_sel       = ctrl_q.ret_sel;
    assign alu_op        = ctrl_q.alu_op;
    assign ret_addr      = ret_addr_q;
    assign halted        = state_q == HALTED;
    assign stk_overflow  = ovf_q;
    assign stk_underflow = unf_q;
endmodule

// File: tb/tb_pipelined_controller.sv
// tb_pipelined_controller: directed vectors with hand-computed control words,
// run against a 4-deep return stack.
module tb_pipelined_controller;
    logic        clk = 1'b0;
    logic        rst, instr_valid, stall, flush;
    logic [18:0] instr;
    logic [11:0] pc_next;
    logic        ctrl_valid, reg_write, const_en, mem_read, mem_write, mem_to_reg;
    logic        reg_two_addr, branch, jump_sel, change, ret_sel;
    logic [3:0]  alu_op;
    logic [11:0] ret_addr;
    logic        halted, stk_overflow, stk_underflow;
    logic [14:0] word;
    int          checks = 0;
    int          errors = 0;

    localparam logic [5:0] I_ALUR = 6'b000100, I_ALUI = 6'b010010, I_SHIFT = 6'b110110;
    localparam logic [5:0] I_LOAD = 6'b100000, I_STORE = 6'b100010, I_MEMX = 6'b100100;
    localparam logic [5:0] I_BR = 6'b101000, I_JMP = 6'b111000, I_CALL = 6'b111010;
    localparam logic [5:0] I_RET = 6'b111100, I_NOP = 6'b111110;

    // {valid, reg_write, const_en, mem_read, mem_write, mem_to_reg, reg_two_addr, branch, jump_sel, change, ret_sel, alu_op}
    localparam logic [14:0] W_ALUR  = {11'b11000000010, 4'b0010};
    localparam logic [14:0] W_ALUI  = {11'b11100000010, 4'b0001};
    localparam logic [14:0] W_SHIFT = {11'b11000000000, 4'b1011};
    localparam logic [14:0] W_LOAD  = {11'b11110110000, 4'b0000};
    localparam logic [14:0] W_STORE = {11'b10101110000, 4'b0000};
    localparam logic [14:0] W_MEMX  = {11'b10100110000, 4'b0000};
    localparam logic [14:0] W_BR    = {11'b10000001000, 4'b0000};
    localparam logic [14:0] W_JMP   = {11'b10000000100, 4'b0000};
    localparam logic [14:0] W_RET   = {11'b10000000001, 4'b0000};
    localparam logic [14:0] W_NOP   = {11'b10000000000, 4'b0000};
    localparam logic [14:0] W_BUB   = 15'd0;

    logic [5:0]  sw_op  [9] = '{I_ALUR, I_ALUI, I_SHIFT, I_LOAD, I_STORE, I_MEMX, I_BR, I_JMP, I_NOP};
    logic [14:0] sw_exp [9] = '{W_ALUR, W_ALUI, W_SHIFT, W_LOAD, W_STORE, W_MEMX, W_BR, W_JMP, W_NOP};

    pipelined_controller #(.INSTR_W(19), .PC_W(12), .STACK_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_next       (pc_next),
        .stall         (stall),
        .flush         (flush),
        .ctrl_valid    (ctrl_valid),
        .reg_write     (reg_write),
        .const_en      (const_en),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_two_addr  (reg_two_addr),
        .branch        (branch),
        .jump_sel      (jump_sel),
        .change        (change),
        .ret_sel       (ret_sel),
        .alu_op        (alu_op),
        .ret_addr      (ret_addr),
        .halted        (halted),
        .stk_overflow  (stk_overflow),
        .stk_underflow (stk_underflow)
    );

    assign word = {ctrl_valid, reg_write, const_en, mem_read, mem_write, mem_to_reg,
                   reg_two_addr, branch, jump_sel, change, ret_sel, alu_op};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [5:0] op, input logic [11:0] pc);
        instr       = {op, 13'h00A5};
        pc_next     = pc;
        instr_valid = 1'b1;
        step();
    endtask

    task automatic flags(input string tag, input logic h, input logic o, input logic u);
        check({tag, "_halted"}, 32'(halted), 32'(h));
        check({tag, "_ovf"}, 32'(stk_overflow), 32'(o));
        check({tag, "_unf"}, 32'(stk_underflow), 32'(u));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; instr_valid = 1'b1;
        instr = '1; pc_next = '1;
        step();
        step();
        check("rst_word", 32'(word), 32'(W_BUB));
        check("rst_ret_addr", 32'(ret_addr), 32'd0);
        flags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            apply(sw_op[i], 12'h000);
            check($sformatf("decode_%0d", i), 32'(word), 32'(sw_exp[i]));
        end
        instr_valid = 1'b0;
        step();
        check("invalid_bubble", 32'(word), 32'(W_BUB));
        apply(I_JMP, 12'h000);
        flush = 1'b1;
        apply(I_ALUR, 12'h000);
        check("flush_bubble", 32'(word), 32'(W_BUB));
        flush = 1'b0;

        for (int k = 1; k <= 3; k++) begin
            apply(I_CALL, 12'(k * 16));
            check($sformatf("call_%0d", k), 32'(word), 32'(W_JMP));
        end
        for (int k = 3; k >= 1; k--) begin
            apply(I_RET, 12'h000);
            check($sformatf("ret_word_%0d", k), 32'(word), 32'(W_RET));
            check($sformatf("ret_addr_%0d", k), 32'(ret_addr), 32'(k * 16));
        end

        apply(I_CALL, 12'h040);
        check("call_040", 32'(word), 32'(W_JMP));
        apply(I_ALUR, 12'h000);
        stall = 1'b1;
        apply(I_CALL, 12'h050);
        check("stall_hold", 32'(word), 32'(W_ALUR));
        flush = 1'b1;
        apply(I_RET, 12'h000);
        check("flush_stall_bubble", 32'(word), 32'(W_BUB));
        check("flush_stall_ret_addr", 32'(ret_addr), 32'd0);
        flush = 1'b0; stall = 1'b0;
        apply(I_RET, 12'h000);
        check("ret_after_stall", 32'(word), 32'(W_RET));
        check("ret_after_stall_addr", 32'(ret_addr), 32'h040);
        apply(I_RET, 12'h000);
        check("underflow_bubble", 32'(word), 32'(W_BUB));
        flags("underflow", 1'b1, 1'b0, 1'b1);
        apply(I_ALUI, 12'h000);
        check("halted_bubble_u", 32'(word), 32'(W_BUB));
        flags("underflow_hold", 1'b1, 1'b0, 1'b1);

        rst = 1'b1;
        apply(I_ALUI, 12'h000);
        check("rst2_word", 32'(word), 32'(W_BUB));
        flags("rst2", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            apply(I_CALL, 12'(k));
            check($sformatf("fill_%0d", k), 32'(word), 32'(W_JMP));
        end
        check("full_not_halted", 32'(halted), 32'd0);
        apply(I_CALL, 12'h005);
        check("overflow_bubble", 32'(word), 32'(W_BUB));
        flags("overflow", 1'b1, 1'b1, 1'b0);
        apply(I_RET, 12'h000);
        check("halted_bubble_o", 32'(word), 32'(W_BUB));
        check("halted_ret_addr", 32'(ret_addr), 32'd0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        flags("rst3", 1'b0, 1'b0, 1'b0);
        instr = '1;
        step();
        check("halt_bubble", 32'(word), 32'(W_BUB));
        flags("halt", 1'b1, 1'b0, 1'b0);
        apply(I_JMP, 12'h000);
        check("halt_hold_bubble", 32'(word), 32'(W_BUB));
        rst = 1'b1; stall = 1'b1;
        apply(I_JMP, 12'h000);
        check("rst_in_stall_word", 32'(word), 32'(W_BUB));
        flags("rst_in_stall", 1'b0, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b0;
        apply(I_ALUI, 12'h000);
        check("alui_after_rst", 32'(word), 32'(W_ALUI));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
